// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned FETCH_DEPTH = 2;
    localparam logic [63:0] ALIGN_MASK  = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] nextseqpc;
    } fetch_entry_t;

    // Sequential successor of a fetch address, wrapping modulo 2^64.
    function automatic logic [63:0] seq_pc(input logic [63:0] addr);
        return addr + 64'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry synchronous FIFO with flush; head entry is always visible on head_o.
module fetch_fifo2
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    localparam logic [1:0] FULL = 2'(FETCH_DEPTH);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop_s, push_s;

    // Next-state: head/tail shift structure; a push at full is accepted only alongside a pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_s   = pop_i && (count_q != 2'd0);
        push_s  = push_i && ((count_q != FULL) || pop_s);
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = data_i;
                    end else begin
                        tail_d = data_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = data_i;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, tracks in-flight requests,
// drops responses killed by a redirect and queues instructions toward IF/ID.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [63:0] if_nextseqpc
);

    logic [63:0]  pc_q, pc_d;
    logic [1:0]   drop_q, drop_d;
    logic [1:0]   pend_count_s, outq_count_s;
    logic [63:0]  pend_head_s;
    fetch_entry_t outq_head_s, outq_push_s;
    logic [2:0]   total_s, occupancy_s, drop_next_s;
    logic         req_valid_s, issue_s, rsp_s, rsp_live_s, if_valid_s, if_pop_s;

    // Issue throttle, response classification and handshake decode.
    always_comb begin
        total_s     = {1'b0, pend_count_s} + {1'b0, drop_q};
        occupancy_s = {1'b0, pend_count_s} + {1'b0, outq_count_s};
        req_valid_s = !reset && !redirect_valid && (total_s < 3'd2) && (occupancy_s < 3'd2);
        issue_s     = req_valid_s && imem_req_ready;
        rsp_s       = imem_rsp_valid && !reset;
        rsp_live_s  = rsp_s && !redirect_valid && (drop_q == 2'd0);
        if_valid_s  = !reset && (outq_count_s != 2'd0);
        if_pop_s    = if_valid_s && if_ready;
        outq_push_s.instr     = imem_rsp_data;
        outq_push_s.nextseqpc = pend_head_s;
    end

    // Next pc and drop counter; a response landing in the redirect cycle retires one in-flight slot.
    always_comb begin
        pc_d        = pc_q;
        drop_next_s = {1'b0, drop_q};
        if (redirect_valid) begin
            pc_d = redirect_pc & ALIGN_MASK;
            if (rsp_s && (total_s != 3'd0)) begin
                drop_next_s = total_s - 3'd1;
            end else begin
                drop_next_s = total_s;
            end
        end else if (issue_s) begin
            pc_d = seq_pc(pc_q);
            if (rsp_s && (drop_q != 2'd0)) begin
                drop_next_s = {1'b0, drop_q} - 3'd1;
            end else begin
                drop_next_s = {1'b0, drop_q};
            end
        end else begin
            pc_d = pc_q;
            if (rsp_s && (drop_q != 2'd0)) begin
                drop_next_s = {1'b0, drop_q} - 3'd1;
            end else begin
                drop_next_s = {1'b0, drop_q};
            end
        end
        drop_d = drop_next_s[1:0];
    end

    // pc and drop counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC & ALIGN_MASK;
            drop_q <= 2'd0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo2 #(
        .WIDTH (64)
    ) u_pend (
        .clk_i   (clk),
        .reset_i (reset),
        .flush_i (redirect_valid),
        .push_i  (issue_s),
        .data_i  (seq_pc(pc_q)),
        .pop_i   (rsp_live_s),
        .head_o  (pend_head_s),
        .count_o (pend_count_s)
    );

    fetch_fifo2 #(
        .WIDTH ($bits(fetch_entry_t))
    ) u_outq (
        .clk_i   (clk),
        .reset_i (reset),
        .flush_i (redirect_valid),
        .push_i  (rsp_live_s),
        .data_i  (outq_push_s),
        .pop_i   (if_pop_s),
        .head_o  (outq_head_s),
        .count_o (outq_count_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_s;
    assign if_instr       = if_valid_s ? outq_head_s.instr : 32'h0;
    assign if_nextseqpc   = if_valid_s ? outq_head_s.nextseqpc : 64'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences and
// randomized traffic against a request-level scoreboard of the fetch stream.
module tb_fetch_unit;

    localparam logic [63:0] RPC = 64'h1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [63:0] if_nextseqpc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_nextseqpc   (if_nextseqpc)
    );

    typedef struct { logic [63:0] addr; int gen; int due; } mreq_t;
    typedef struct { logic [31:0] instr; logic [63:0] nseq; } exp_t;
    typedef struct { logic rdy; logic ifr; logic rv; logic [63:0] addr; logic ifv; logic [63:0] nseq; } vec_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          gen_cur = 0, cyc = 0, nerr = 0, nchk = 0, n_issue = 0;
    int          lat_min = 1, lat_max = 1;
    logic [63:0] exp_pc = RPC;

    logic        k_reset = 1'b1, k_redir = 1'b0, k_ifr = 1'b1, k_rdy = 1'b1;
    logic [63:0] k_rpc = 64'h0;
    logic        s_rv, s_ifv, s_issue;
    logic [63:0] s_addr, s_nseq;
    logic [31:0] s_instr;

    function automatic logic [31:0] mdata(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            if (nerr <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, {63'h0, act}, {63'h0, exp});
    endtask

    // One clock cycle: drive knobs and memory response, check against the scoreboard, advance it.
    task automatic step();
        int    live;
        logic  exp_rv;
        bit    rsp_live;
        mreq_t f;
        rsp_live = 1'b0;
        @(negedge clk);
        reset          = k_reset;
        redirect_valid = k_redir;
        redirect_pc    = k_rpc;
        if_ready       = k_ifr;
        imem_req_ready = k_rdy;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mdata(mem_q[0].addr);
        end
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr; s_ifv = if_valid;
        s_instr = if_instr; s_nseq = if_nextseqpc;
        s_issue = s_rv && k_rdy;
        live = 0;
        foreach (mem_q[i]) if (mem_q[i].gen == gen_cur) live++;
        exp_rv = !k_reset && !k_redir && (mem_q.size() < 2) && ((live + exp_q.size()) < 2);
        chkb("req_valid", s_rv, exp_rv);
        if (k_reset) begin
            chkb("rst_if_valid", s_ifv, 1'b0);
            chk("rst_if_instr", {32'h0, s_instr}, 64'h0);
            chk("rst_if_nseq", s_nseq, 64'h0);
        end else begin
            chkb("if_valid", s_ifv, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("if_instr", {32'h0, s_instr}, {32'h0, exp_q[0].instr});
                chk("if_nseq", s_nseq, exp_q[0].nseq);
            end else begin
                chk("idle_if_instr", {32'h0, s_instr}, 64'h0);
                chk("idle_if_nseq", s_nseq, 64'h0);
            end
            if (s_issue) chk("req_addr", s_addr, exp_pc);
        end
        if (imem_rsp_valid) begin
            f = mem_q.pop_front();
            rsp_live = !k_reset && !k_redir && (f.gen == gen_cur);
        end
        if (!k_reset && k_ifr && exp_q.size() != 0) void'(exp_q.pop_front());
        if (rsp_live) exp_q.push_back('{instr: mdata(f.addr), nseq: f.addr + 64'd4});
        if (s_issue) begin
            mem_q.push_back('{addr: s_addr, gen: gen_cur,
                              due: cyc + int'($urandom_range(lat_max, lat_min))});
            n_issue++;
        end
        if (exp_rv && k_rdy) exp_pc = exp_pc + 64'd4;
        if (k_reset) begin
            mem_q.delete(); exp_q.delete();
            exp_pc = RPC; gen_cur++;
        end else if (k_redir) begin
            exp_q.delete(); gen_cur++;
            exp_pc = k_rpc & 64'hFFFF_FFFF_FFFF_FFFC;
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        k_reset = 1'b1; k_redir = 1'b0; k_rdy = 1'b1; k_ifr = 1'b1;
        repeat (n) step();
        k_reset = 1'b0;
    endtask

    initial begin
        vec_t        tbl[7];
        int          n0;
        bit          seen_addr, seen_if;
        logic [63:0] first_addr, first_nseq;

        // After reset, 1-cycle memory, always ready: issue/deliver pattern repeats every 3 cycles.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 64'h1000, 1'b0, 64'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 64'h1004, 1'b0, 64'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 64'h1008, 1'b1, 64'h1004};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 64'h1008, 1'b1, 64'h1008};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 64'h100C, 1'b0, 64'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 64'h1010, 1'b1, 64'h100C};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 64'h1010, 1'b1, 64'h1010};

        lat_min = 1; lat_max = 1;
        do_reset(3);
        for (int i = 0; i < 7; i++) begin
            k_rdy = tbl[i].rdy; k_ifr = tbl[i].ifr;
            step();
            chkb("tbl_rv", s_rv, tbl[i].rv);
            chk("tbl_addr", s_addr, tbl[i].addr);
            chkb("tbl_ifv", s_ifv, tbl[i].ifv);
            chk("tbl_nseq", s_nseq, tbl[i].nseq);
        end

        // Downstream stall: fetching stops within two requests, then drains in order.
        n0 = n_issue; k_ifr = 1'b0;
        repeat (10) step();
        chkb("stall_issue_bound", (n_issue - n0) <= 2, 1'b1);
        chkb("stall_rv_low", s_rv, 1'b0);
        k_ifr = 1'b1;
        repeat (8) step();

        // Redirect with two requests outstanding.
        lat_min = 3; lat_max = 3;
        do_reset(2);
        n0 = n_issue;
        step(); step();
        chk("two_outstanding", 64'(n_issue - n0), 64'd2);
        k_redir = 1'b1; k_rpc = 64'h2003;
        step();
        k_redir = 1'b0;
        seen_addr = 1'b0; seen_if = 1'b0; first_addr = 64'h0; first_nseq = 64'h0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!seen_addr && s_issue) begin seen_addr = 1'b1; first_addr = s_addr; end
            if (!seen_if && s_ifv) begin seen_if = 1'b1; first_nseq = s_nseq; end
        end
        chkb("redir_issue_seen", seen_addr, 1'b1);
        chk("redir_first_addr", first_addr, 64'h2000);
        chkb("redir_if_seen", seen_if, 1'b1);
        chk("redir_first_nseq", first_nseq, 64'h2004);

        // Redirect coinciding with a response and a head pop.
        lat_min = 1; lat_max = 1;
        do_reset(2);
        k_ifr = 1'b0;
        step(); step();
        k_ifr = 1'b1; k_redir = 1'b1; k_rpc = 64'h3000;
        step();
        chkb("rdpop_ifv", s_ifv, 1'b1);
        k_redir = 1'b0;
        step();
        chkb("rdpop_q_empty", s_ifv, 1'b0);
        chkb("rdpop_rv", s_rv, 1'b1);
        chk("rdpop_addr", s_addr, 64'h3000);

        // Memory back-pressure: address stable, a single acceptance.
        do_reset(2);
        n0 = n_issue; k_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_addr", s_addr, 64'h1000);
            chkb("bp_rv", s_rv, 1'b1);
        end
        k_rdy = 1'b1; step();
        k_rdy = 1'b0; step();
        chk("bp_issue_once", 64'(n_issue - n0), 64'd1);
        chk("bp_addr_next", s_addr, 64'h1004);

        // pc wrap at the top of the address space.
        do_reset(2);
        k_rdy = 1'b1; k_redir = 1'b1; k_rpc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        k_redir = 1'b0;
        step();
        chk("wrap_addr_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_addr_zero", s_addr, 64'h0);
        step();
        chkb("wrap_ifv", s_ifv, 1'b1);
        chk("wrap_nseq", s_nseq, 64'h0);

        // Randomized traffic against the scoreboard.
        lat_min = 1; lat_max = 4;
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            k_reset = ($urandom_range(199, 0) == 0);
            k_redir = ($urandom_range(19, 0) == 0);
            k_rpc   = {$urandom(), $urandom()};
            if ($urandom_range(3, 0) == 0) k_rpc = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, k_rpc[3:0]};
            k_ifr   = ($urandom_range(9, 0) < 7);
            k_rdy   = ($urandom_range(3, 0) != 0);
            step();
        end
        k_reset = 1'b0; k_redir = 1'b0; k_ifr = 1'b1; k_rdy = 1'b1;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
